// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC sequencing, synchronous instruction memory,
// fault detection and a prefetch FIFO feeding decode through valid/ready.
module fetch_queue_unit #(
    parameter int               XLEN       = 64,
    parameter int               IMEM_DEPTH = 1024,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [31:0]                   out_instr,
    output logic                          out_fault,
    output logic                          fetch_halted,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0]      mem [IMEM_DEPTH];
    logic [XLEN-1:0]  fpc;
    logic             rsp_v;
    logic [XLEN-1:0]  rsp_pc;
    logic [31:0]      rsp_instr;
    logic             rsp_fault;

    logic [XLEN-1:0]  pc_q    [FIFO_DEPTH];
    logic [31:0]      instr_q [FIFO_DEPTH];
    logic             fault_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [CW:0]      occupancy;
    logic             issue;
    logic             issue_fault;
    logic             push;
    logic             pop;

    // Handshake: decode takes the head on any rising edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready.

    // Queued entries plus the one in flight must leave room for a new issue.
    always_comb begin
        occupancy   = {1'b0, count} + (CW + 1)'(rsp_v);
        issue_fault = (|fpc[1:0]) || (|fpc[XLEN-1:AW+2]);
        issue       = !fetch_halted && !redirect_valid && (occupancy < DEPTH_W);
        push        = rsp_v && !redirect_valid;
        pop         = out_valid && out_ready && !redirect_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = FETCH_RUN;
        end else if (issue && issue_fault) begin
            state_next = FETCH_HALTED;
        end
    end

    always_comb begin
        fetch_halted = (state == FETCH_HALTED);
    end

    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    // The memory read happens on the issue edge; a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc       <= RESET_PC;
            rsp_v     <= 1'b0;
            rsp_pc    <= '0;
            rsp_instr <= '0;
            rsp_fault <= 1'b0;
        end else if (redirect_valid) begin
            fpc   <= redirect_pc;
            rsp_v <= 1'b0;
        end else begin
            rsp_v <= issue;
            if (issue) begin
                fpc       <= fpc + XLEN'(4);
                rsp_pc    <= fpc;
                rsp_fault <= issue_fault;
                rsp_instr <= issue_fault ? NOP : mem[fpc[AW+1:2]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= rsp_pc;
            instr_q[wr_ptr] <= rsp_instr;
            fault_q[wr_ptr] <= rsp_fault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        out_valid = (count != '0);
        out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
        out_instr = out_valid ? instr_q[rd_ptr] : '0;
        out_fault = out_valid ? fault_q[rd_ptr] : 1'b0;
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed latency/backpressure/redirect/fault
// scenarios followed by random out_ready and redirect traffic.
module tb_fetch_queue_unit;

    localparam int XLEN       = 64;
    localparam int IMEM_DEPTH = 1024;
    localparam int FIFO_DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_instr;
    logic              out_fault;
    logic              fetch_halted;
    logic              imem_we;
    logic [9:0]        imem_waddr;
    logic [31:0]       imem_wdata;

    // clock / reset
    always #5 clk = ~clk;

    fetch_queue_unit #(
        .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_fault(out_fault), .fetch_halted(fetch_halted),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata)
    );

    // reference model and scoreboard state
    logic [31:0]  mem_m [IMEM_DEPTH];
    logic [96:0]  exp_q[$];
    logic [63:0]  gen_pc;
    bit           gen_halted;
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_pops   = 0;
    logic         last_valid;
    logic [63:0]  last_pc;
    logic [31:0]  last_instr;
    logic         last_fault;
    logic         last_halted;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected entry for a fetch address: {fault, instr, pc}.
    function automatic logic [96:0] model_entry(input logic [63:0] pc);
        logic        f;
        logic [31:0] ins;
        f = (pc % 64'd4 != 64'd0) || (pc >= 64'(4 * IMEM_DEPTH));
        if (f) ins = NOP;
        else   ins = mem_m[int'(pc / 64'd4)];
        return {f, ins, pc};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        gen_pc     = 64'd0;
        gen_halted = 1'b0;
    endtask

    // Called after inputs are set for the coming edge, before that edge.
    task automatic sb_step();
        logic [96:0] e;
        last_valid  = out_valid;
        last_pc     = out_pc;
        last_instr  = out_instr;
        last_fault  = out_fault;
        last_halted = fetch_halted;
        if (!out_valid)
            check("idle_outputs", out_pc | 64'(out_instr) | 64'(out_fault), 64'd0);
        if (out_valid && out_ready) begin
            n_pops++;
            if (exp_q.size() == 0 && !gen_halted) begin
                e = model_entry(gen_pc);
                exp_q.push_back(e);
                gen_pc = gen_pc + 64'd4;
                if (e[96]) gen_halted = 1'b1;
            end
            if (exp_q.size() == 0) begin
                check("entry_after_fault", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", out_pc, e[63:0]);
                check("pop_instr", 64'(out_instr), 64'(e[95:64]));
                check("pop_fault", 64'(out_fault), 64'(e[96]));
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            gen_pc     = redirect_pc;
            gen_halted = 1'b0;
        end
    endtask

    // driver tasks (all start and end at a falling edge)
    task automatic cycle(input logic rdy, input logic rv, input logic [63:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        sb_step();
        @(negedge clk);
    endtask

    task automatic write_mem(input int addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = 10'(addr);
        imem_wdata = data;
        @(negedge clk);
        mem_m[addr] = data;
        imem_we     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic do_release();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic fault_case(input logic [63:0] pc);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, k == 0, pc);
            if (k >= 1) check("fault_halted", 64'(last_halted), 64'(k >= 2));
            if (k >= 1 && k != 3) check("fault_quiet", 64'(last_valid), 64'd0);
            if (k == 3) begin
                check("fault_valid", 64'(last_valid), 64'd1);
                check("fault_flag", 64'(last_fault), 64'd1);
                check("fault_instr", 64'(last_instr), 64'(NOP));
                check("fault_pc", last_pc, pc);
            end
        end
    endtask

    initial begin
        int n0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_we        = 1'b0;
        imem_waddr     = '0;
        imem_wdata     = '0;
        rst_n          = 1'b0;
        @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", out_pc | 64'(out_instr) | 64'(out_fault), 64'd0);
        check("reset_halted", 64'(fetch_halted), 64'd0);

        for (int i = 0; i < IMEM_DEPTH; i++)
            write_mem(i, (i < 8) ? 32'h1000 + 32'(i) : $urandom);

        // sequential fetch: first valid in cycle 2, then one per cycle
        do_release();
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 1'b0, '0);
            check("seq_valid", 64'(last_valid), 64'(k >= 2));
        end

        // asynchronous reset between edges while the FIFO holds entries
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 64'(out_valid), 64'd0);
        check("areset_outputs", out_pc | 64'(out_instr) | 64'(out_fault), 64'd0);
        check("areset_halted", 64'(fetch_halted), 64'd0);
        @(negedge clk);
        model_reset();

        // backpressure then release
        do_release();
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, '0);
            check("bp_valid", 64'(last_valid), 64'(k >= 2));
            if (k >= 2) check("bp_hold_pc", last_pc, 64'd0);
        end
        n0 = n_pops;
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, '0);
        check("bp_drain_count", 64'(n_pops - n0), 64'd8);

        // redirect with pc 0x8 in flight and 0xC about to issue
        do_reset();
        do_release();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, k == 3, 64'h40);
            if (k == 4 || k == 5) check("redir_gap", 64'(last_valid), 64'd0);
            if (k == 6) begin
                check("redir_valid", 64'(last_valid), 64'd1);
                check("redir_pc", last_pc, 64'h40);
                check("redir_instr", 64'(last_instr), 64'(mem_m[16]));
            end
        end

        // faults: misaligned, out of range, then recover with a fresh word
        fault_case(64'h102);
        fault_case(64'h1000);
        write_mem(2, 32'hDEAD_BEEF);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, k == 0, 64'h8);
            if (k == 1) check("resume_halted", 64'(last_halted), 64'd0);
            if (k == 3) begin
                check("resume_pc", last_pc, 64'h8);
                check("resume_instr", 64'(last_instr), 64'hDEAD_BEEF);
            end
        end

        // random traffic
        n0 = n_pops;
        for (int k = 0; k < 800; k++) begin
            logic        rdy;
            logic        rv;
            logic [63:0] rpc;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0) || (last_halted && $urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0, 1, 2: rpc = 64'($urandom_range(0, IMEM_DEPTH - 1)) * 64'd4;
                3:       rpc = 64'hFF0 + 64'd4 * 64'($urandom_range(0, 3));
                4:       rpc = 64'($urandom_range(0, 4 * IMEM_DEPTH - 1)) | 64'd1;
                default: rpc = 64'hFFFF_FFFF_FFFF_FFF8;
            endcase
            cycle(rdy, rv, rpc);
        end
        check("rand_progress", 64'(n_pops - n0 >= 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
